full_adder: RTL and testbench

FULL_ADDER -- requirements
Module: full_adder

---
 rtl/full_adder_bit.sv | 13 +
 rtl/full_adder.sv | 50 +++++
 tb/tb_full_adder.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/full_adder_bit.sv
// One-bit full adder cell: the ripple-chain building block of full_adder.
module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/full_adder.sv
// WIDTH-bit ripple-carry adder with combinational sum/carry and a
// one-cycle registered copy of both, cleared by an asynchronous reset.
module full_adder #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic [WIDTH-1:0] sum_q,
  output logic             carry_q
);

  // carry_chain[i] is the carry into bit i; the top entry is the carry-out.
  logic [WIDTH:0]   carry_chain;
  logic [WIDTH-1:0] sum_d;
  logic             carry_d;

  assign carry_chain[0] = c;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    full_adder_bit u_bit (
      .a  (a[i]),
      .b  (b[i]),
      .ci (carry_chain[i]),
      .s  (sum[i]),
      .co (carry_chain[i+1])
    );
  end

  assign carry   = carry_chain[WIDTH];
  assign sum_d   = sum;
  assign carry_d = carry;

  // NOTE: registers use non-blocking assignments so every flop samples its
  // input from before the edge; reset is in the sensitivity list to act at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      carry_q <= carry_d;
    end
  end

endmodule

// File: tb/tb_full_adder.sv
// Directed bench for full_adder: a 1-bit and a 4-bit instance share clock
// and reset; expected values are hand-computed constants.
module tb_full_adder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       a1, b1, c1;
  logic       sum1, carry1, sum_q1, carry_q1;
  logic [3:0] a4, b4;
  logic       c4;
  logic [3:0] sum4, sum_q4;
  logic       carry4, carry_q4;

  int checks = 0;
  int errors = 0;

  // Period 10: rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  full_adder #(.WIDTH(1)) u_dut1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .a       (a1),
    .b       (b1),
    .c       (c1),
    .sum     (sum1),
    .carry   (carry1),
    .sum_q   (sum_q1),
    .carry_q (carry_q1)
  );

  full_adder #(.WIDTH(4)) u_dut4 (
    .clk     (clk),
    .rst_n   (rst_n),
    .a       (a4),
    .b       (b4),
    .c       (c4),
    .sum     (sum4),
    .carry   (carry4),
    .sum_q   (sum_q4),
    .carry_q (carry_q4)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Required {sum,carry} for (a,b,c) = 000 .. 111.
  logic [1:0] exp_sc [8] = '{2'b00, 2'b10, 2'b10, 2'b01, 2'b10, 2'b01, 2'b01, 2'b11};

  initial begin
    a1 = 1'b0; b1 = 1'b0; c1 = 1'b0;
    a4 = 4'h0; b4 = 4'h0; c4 = 1'b0;

    // Reset held from time 0; registered outputs must already be clear.
    #2;
    check("rst_sum_q1",   {7'd0, sum_q1},   8'h00);
    check("rst_carry_q1", {7'd0, carry_q1}, 8'h00);
    check("rst_sum_q4",   {4'd0, sum_q4},   8'h00);
    check("rst_carry_q4", {7'd0, carry_q4}, 8'h00);

    // Full truth table of the 1-bit adder, 10 time units per vector, while
    // reset is still asserted (combinational path must be unaffected).
    for (int i = 0; i < 8; i++) begin
      {a1, b1, c1} = 3'(i);
      #1;
      check($sformatf("tt1_%0d", i), {6'd0, sum1, carry1}, {6'd0, exp_sc[i]});
      check($sformatf("tt1_q_%0d", i), {6'd0, sum_q1, carry_q1}, 8'h00);
      #9;
    end

    // Now at t=82, between edges. Release reset and drive all-ones / wrap case.
    rst_n = 1'b1;
    a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
    a4 = 4'hF; b4 = 4'h1; c4 = 1'b1;
    #1;
    check("wrap_sum4",   {4'd0, sum4},   8'h01);
    check("wrap_carry4", {7'd0, carry4}, 8'h01);
    @(posedge clk); #1;
    check("ones_sum_q1",   {7'd0, sum_q1},   8'h01);
    check("ones_carry_q1", {7'd0, carry_q1}, 8'h01);
    check("wrap_sum_q4",   {4'd0, sum_q4},   8'h01);
    check("wrap_carry_q4", {7'd0, carry_q4}, 8'h01);

    // Mid-cycle reset: registers clear immediately, combinational outputs hold.
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_sum_q4",   {4'd0, sum_q4},   8'h00);
    check("midrst_carry_q4", {7'd0, carry_q4}, 8'h00);
    check("midrst_sum_q1",   {7'd0, sum_q1},   8'h00);
    check("midrst_sum4",     {4'd0, sum4},     8'h01);
    check("midrst_carry4",   {7'd0, carry4},   8'h01);

    // A clock edge during reset must not load anything.
    @(posedge clk); #1;
    check("hold_sum_q4",   {4'd0, sum_q4},   8'h00);
    check("hold_carry_q4", {7'd0, carry_q4}, 8'h00);

    // Release with 3+4+1: one edge later sum_q=8, carry_q=0.
    #3;
    a4 = 4'h3; b4 = 4'h4; c4 = 1'b1;
    rst_n = 1'b1;
    #1;
    check("rel_sum4", {4'd0, sum4}, 8'h08);
    @(posedge clk); #1;
    check("rel_sum_q4",   {4'd0, sum_q4},   8'h08);
    check("rel_carry_q4", {7'd0, carry_q4}, 8'h00);

    // 7+8+0: full-range sum without carry.
    #3;
    a4 = 4'h7; b4 = 4'h8; c4 = 1'b0;
    #1;
    check("max_sum4",   {4'd0, sum4},   8'h0F);
    check("max_carry4", {7'd0, carry4}, 8'h00);
    @(posedge clk); #1;
    check("max_sum_q4", {4'd0, sum_q4}, 8'h0F);

    // F+F+1 = 0x1F: largest input, carry must ripple all the way.
    #3;
    a4 = 4'hF; b4 = 4'hF; c4 = 1'b1;
    #1;
    check("ff_sum4",   {4'd0, sum4},   8'h0F);
    check("ff_carry4", {7'd0, carry4}, 8'h01);
    @(posedge clk); #1;
    check("ff_carry_q4", {7'd0, carry_q4}, 8'h01);

    // 5+A+0 = F and 5+A+1 = 0x10: carry-in alone flips every sum bit.
    #3;
    a4 = 4'h5; b4 = 4'hA; c4 = 1'b0;
    #1;
    check("alt_sum4", {4'd0, sum4}, 8'h0F);
    c4 = 1'b1;
    #1;
    check("alt_ci_sum4",   {4'd0, sum4},   8'h00);
    check("alt_ci_carry4", {7'd0, carry4}, 8'h01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
